// File: rtl/beepboop_pkg.sv
// Shared types and constants for the beepboop serial-ID receiver.
// The signature is stored as a packed string; sig_rom() returns one byte of it by index.
package beepboop_pkg;

    typedef enum logic [1:0] {IDLE, RECV, DONE, ERR} rx_state_t;

    localparam int unsigned FRAME_BITS = 192;
    localparam int unsigned SIG_LEN    = 17;
    localparam logic [8*SIG_LEN-1:0] SIG_STR = "roboclub beepboop";
    localparam logic [7:0] PAD_BYTE = 8'h00;

    // Byte idx of the signature, first character first; PAD_BYTE past its end.
    function automatic logic [7:0] sig_rom(input int unsigned idx);
        if (idx < SIG_LEN) begin
            return SIG_STR[8*(SIG_LEN-1-idx) +: 8];
        end
        return PAD_BYTE;
    endfunction

endpackage

// File: rtl/beepboop_rx_if.sv
// Valid/ready byte stream leaving the receiver.
interface beepboop_rx_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/beepboop_byte_fifo.sv
// Small synchronous FIFO with no write-to-read bypass.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module beepboop_byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] pop_data
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Head is forced to zero while empty so stale entries never leak out.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/beepboop_rx.sv
// Deserializes the MSB-first beepboop ID stream into bytes, queues them in a FIFO
// and checks each frame against the signature followed by zero padding.
module beepboop_rx
    import beepboop_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = FRAME_BITS / 8,
    parameter int unsigned SIG_BYTES   = SIG_LEN,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ser_bit,
    input  logic          ser_valid,
    beepboop_rx_if.master byte_if,
    output logic [4:0]    byte_count,
    output logic          frame_done,
    output logic          frame_ok,
    output logic          frame_err,
    output logic          overrun
);
    localparam logic [4:0] LAST_COUNT = 5'(FRAME_BYTES);

    rx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [4:0] byte_count_q, byte_count_d;
    logic       mismatch_q, mismatch_d;
    logic       frame_ok_q, frame_ok_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q;
    logic       push;
    logic [7:0] assembled, expected;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_data;

    assign assembled = {shift_q[6:0], ser_bit};
    assign expected  = (32'(byte_count_q) < SIG_BYTES) ? sig_rom(32'(byte_count_q)) : PAD_BYTE;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_count_d = byte_count_q;
        mismatch_d   = mismatch_q;
        frame_ok_d   = frame_ok_q;
        frame_err_d  = frame_err_q;
        push         = 1'b0;
        unique case (state_q)
            // DONE lasts one cycle and may start the next frame just like IDLE.
            IDLE, DONE: begin
                state_d = IDLE;
                if (ser_valid) begin
                    state_d      = RECV;
                    shift_d      = {7'b0, ser_bit};
                    bit_cnt_d    = 3'd1;
                    byte_count_d = '0;
                    mismatch_d   = 1'b0;
                    frame_ok_d   = 1'b0;
                    frame_err_d  = 1'b0;
                end
            end
            RECV: begin
                if (ser_valid) begin
                    if (byte_count_q == LAST_COUNT) begin
                        state_d     = ERR;
                        frame_err_d = 1'b1;
                    end else begin
                        shift_d   = assembled;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            push         = 1'b1;
                            byte_count_d = byte_count_q + 5'd1;
                            if (assembled != expected) mismatch_d = 1'b1;
                        end
                    end
                end else if (bit_cnt_q != 3'd0 || byte_count_q != LAST_COUNT) begin
                    state_d     = ERR;
                    frame_err_d = 1'b1;
                end else begin
                    state_d    = DONE;
                    frame_ok_d = !mismatch_q;
                end
            end
            ERR: begin
                if (!ser_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_count_q <= '0;
            mismatch_q   <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_count_q <= byte_count_d;
            mismatch_q   <= mismatch_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            // A full FIFO only drops the byte when no pop frees a slot this cycle.
            overrun_q    <= overrun_q | (push & fifo_full & ~byte_if.byte_ready);
        end
    end

    beepboop_byte_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data(assembled),
        .full     (fifo_full),
        .pop      (byte_if.byte_ready),
        .empty    (fifo_empty),
        .pop_data (fifo_data)
    );

    assign byte_if.byte_data  = fifo_data;
    assign byte_if.byte_valid = ~fifo_empty;
    assign byte_count         = byte_count_q;
    assign frame_done         = (state_q == DONE);
    assign frame_ok           = frame_ok_q;
    assign frame_err          = frame_err_q;
    assign overrun            = overrun_q;

endmodule
